// File: rtl/sar_data_receiver.sv
// sar_data_receiver: reassembles two serial beats from the SAR state machine
// into a conversion word, stores the calibration offset, applies saturating
// offset correction to differential words and queues results in a 2-entry FIFO.
module sar_data_receiver #(
  parameter int DATA_W   = 6,
  parameter int MIDSCALE = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  clk_data_i,
  input  logic                  sample_i,
  input  logic                  offset_cal_cycle_i,
  input  logic                  single_ended_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [2*DATA_W:0]     offset_o,
  output logic                  overrun_o,
  output logic                  frame_err_o
);

  localparam int WORD_W = 2 * DATA_W;
  localparam logic [WORD_W:0] MID = MIDSCALE[WORD_W:0];

  typedef enum logic [1:0] {
    WAIT_FRAME,
    WAIT_MSB,
    WAIT_LSB
  } state_t;

  state_t              state, state_nxt;
  logic                clk_data_q, sample_q;
  logic                beat, frame_start;
  logic                msb_load, word_done, frame_err_nxt;
  logic [DATA_W-1:0]   msb_q;
  logic [WORD_W-1:0]   raw_q;
  logic                raw_valid_q, raw_cal_q, raw_se_q;
  logic [WORD_W:0]     offset_q;
  logic [WORD_W:0]     cal_offset;
  logic [WORD_W+1:0]   diff;
  logic [WORD_W-1:0]   corrected, wr_data;
  logic                wr_req, push, pop, full, overrun_nxt;
  logic [WORD_W-1:0]   mem [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;

  assign beat        = clk_data_i & ~clk_data_q;
  assign frame_start = sample_i & ~sample_q;

  // Previous-value flops for rise detection on the strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_data_q <= 1'b0;
      sample_q   <= 1'b0;
    end else begin
      clk_data_q <= clk_data_i;
      sample_q   <= sample_i;
    end
  end

  // Framing state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nxt;
  end

  // Next-state decode; a sample rise always restarts the frame before any beat is used
  always_comb begin
    state_nxt     = state;
    msb_load      = 1'b0;
    word_done     = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      WAIT_FRAME: begin
        if (frame_start) begin
          if (beat) begin
            msb_load  = 1'b1;
            state_nxt = WAIT_LSB;
          end else begin
            state_nxt = WAIT_MSB;
          end
        end
      end
      WAIT_MSB: begin
        if (beat) begin
          msb_load  = 1'b1;
          state_nxt = WAIT_LSB;
        end
      end
      WAIT_LSB: begin
        if (frame_start) begin
          frame_err_nxt = 1'b1;
          if (beat) begin
            msb_load  = 1'b1;
            state_nxt = WAIT_LSB;
          end else begin
            state_nxt = WAIT_MSB;
          end
        end else if (beat) begin
          word_done = 1'b1;
          state_nxt = WAIT_FRAME;
        end
      end
      default: state_nxt = WAIT_FRAME;
    endcase
  end

  // Beat capture and raw word register with its frame attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb_q       <= '0;
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
      raw_cal_q   <= 1'b0;
      raw_se_q    <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (msb_load) msb_q <= data_i;
      if (word_done) begin
        raw_q     <= {msb_q, data_i};
        raw_cal_q <= offset_cal_cycle_i;
        raw_se_q  <= single_ended_i;
      end
      raw_valid_q <= word_done;
      frame_err_o <= frame_err_nxt;
    end
  end

  // Offset and saturating correction; diff is two bits wider so its top bit is the sign
  always_comb begin
    cal_offset = {1'b0, raw_q} - MID;
    diff       = {2'b00, raw_q} - {offset_q[WORD_W], offset_q};
    if (diff[WORD_W+1])  corrected = '0;
    else if (diff[WORD_W]) corrected = '1;
    else                 corrected = diff[WORD_W-1:0];
    wr_data = raw_se_q ? raw_q : corrected;
  end

  assign wr_req      = raw_valid_q & ~raw_cal_q;
  assign full        = (count == 2'd2);
  assign pop         = (count != 2'd0) & result_ready_i;
  assign push        = wr_req & (~full | pop);
  assign overrun_nxt = wr_req & full & ~pop;

  // Offset register updated by calibration frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      offset_q <= '0;
    else if (raw_valid_q && raw_cal_q) offset_q <= cal_offset;
  end

  // Two-entry circular FIFO; a write while full is accepted only alongside a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      overrun_o <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      overrun_o <= overrun_nxt;
    end
  end

  assign result_o       = mem[rd_ptr];
  assign result_valid_o = (count != 2'd0);
  assign offset_o       = offset_q;

endmodule

// File: doc/sar_data_receiver.md
# sar_data_receiver

Digital back-end that receives the SAR state machine's 6-bit serial result bus and reassembles full 12-bit conversion words. It frames beats on the sample and data strobes, stores the offset-calibration result, and applies signed offset correction with saturation to differential conversions. Corrected words go into a 2-entry FIFO drained by a valid/ready handshake toward the system-side interface. All inputs are driven from the `clk` domain.

## Interface

Parameters:
- `DATA_W`, 6: beat width; word width is 2*`DATA_W`.
- `MIDSCALE`, 2048: code subtracted from the calibration word to form the offset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `data_i`  in  6  result beat from the state machine.
- `clk_data_i`  in  1  beat strobe; rising edge marks a valid `data_i`.
- `sample_i`  in  1  sampling phase; rising edge starts a new frame.
- `offset_cal_cycle_i`  in  1  current frame is an offset-calibration conversion.
- `single_ended_i`  in  1  current frame is single-ended; no offset correction.
- `result_o`  out  12  FIFO head, corrected unsigned code.
- `result_valid_o`  out  1  FIFO non-empty.
- `result_ready_i`  in  1  consumer accepts `result_o` when high with valid.
- `offset_o`  out  13  signed two's-complement stored offset.
- `overrun_o`  out  1  one-cycle pulse: completed word dropped, FIFO full.
- `frame_err_o`  out  1  one-cycle pulse: malformed frame discarded.

## Operation

- Edge detection: `clk_data_i` and `sample_i` are each registered into a previous-value flop. A rise means current = 1 and previous = 0.
- FSM states and transitions:
  - **WAIT_FRAME** (reset state): beats are ignored. A `sample_i` rise goes to WAIT_MSB.
  - **WAIT_MSB**: a beat is latched into bits [11:6], then go to WAIT_LSB.
  - **WAIT_LSB**: a beat is latched into bits [5:0]. The raw word is registered with `offset_cal_cycle_i` and `single_ended_i`, then go to WAIT_FRAME.
- `sample_i` rise in WAIT_LSB: the partial word is discarded, `frame_err_o` pulses, and the FSM goes to WAIT_MSB.
- `sample_i` rise and beat in the same cycle: the frame restarts first, and the beat is taken as the MSB of the new frame (the FSM goes to WAIT_LSB). If this happens in WAIT_LSB, `frame_err_o` also pulses.
- Post-processing, one cycle after the LSB beat:
  - **Calibration frame**: `offset_o <= raw - MIDSCALE`, computed in 13-bit signed arithmetic. No FIFO write.
  - **Differential frame**: corrected = raw - `offset_o`, computed in 14-bit signed arithmetic and clamped to 0..4095. The result is written to the FIFO.
  - **Single-ended frame**: raw is written to the FIFO unchanged.
- FIFO: 2 entries with circular pointers.
  - A pop occurs when `result_valid_o` and `result_ready_i` are both high.
  - A write while the FIFO is full with no pop in the same cycle: the new word is dropped, `overrun_o` pulses, and contents are unchanged.
  - A write and a pop in the same cycle while full: the write succeeds.
- Reset values: all outputs 0 (`result_o`, `result_valid_o`, `offset_o`, `overrun_o`, `frame_err_o`). FSM is in WAIT_FRAME, FIFO is empty, edge flops are 0.
- Reset mid-frame or with the FIFO occupied: the partial word and all FIFO contents are lost. The stored offset returns to 0.

## Timing

- Edge N: the first clock edge at which `clk_data_i` is sampled high after being low. The LSB beat is captured at edge N.
- Edge N+1: the FIFO write or offset update occurs.
- `result_valid_o` / `offset_o` change after edge N+1. Latency is 2 cycles from the strobe being sampled high.
- Minimum beat spacing: 2 clocks, because a strobe must return low before it can rise again.
- Consecutive frames: a new frame may start at edge N+1 without loss.
- `result_o` is the registered FIFO head. It is stable while `result_valid_o` is high and no pop occurs.
- `frame_err_o` and `overrun_o` are registered. Each asserts for exactly one cycle after the causing edge.

## Test plan

- **Calibration then differential.** Cal frame with beats 0x20, 0x05 (raw 2053) gives `offset_o` = 5 and no valid. Then differential frame with beats 0x10, 0x00 (raw 1024) gives `result_o` = 1019, valid 2 cycles after the LSB strobe.
- **Saturation.** With offset = -10, a differential frame with raw 4090 gives `result_o` = 4095. With offset = +20, raw 3 gives 0.
- **Single-ended bypass.** With offset = 5, `single_ended_i` = 1 and raw 0xABC gives `result_o` = 0xABC.
- **Overrun.** With `result_ready_i` = 0, complete 3 frames with values 1, 2, 3: `overrun_o` pulses once, on the third frame. Then raise ready: 1 and 2 pop in order, and valid drops.
- **Framing errors.** A `sample_i` rise after only the MSB beat gives a `frame_err_o` pulse and no write. A beat before any `sample_i` after reset is ignored, with no pulses. A same-cycle `sample_i` and strobe rise starts a new frame with that beat as the MSB.
- **Async reset mid-frame.** Assert `rst` with one word in the FIFO and the FSM in WAIT_LSB: all outputs go to 0 immediately. After release, the next full frame produces a correct word.
